// File: rtl/npu_sram_pkg.sv
// Shared constants for the 16kx64 SRAM read path and the read-streamer FSM encoding.
// No ports; imported by the interface, the skid FIFO and the streamer top.
package npu_sram_pkg;

   localparam int SRAM_AW = 14;
   localparam int SRAM_DW = 64;
   localparam int SRAM_LW = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

endpackage

// File: rtl/sram_rd_streamer_if.sv
// SRAM read port plus valid/ready output stream of the read streamer.
// master: streamer side (drives enb/addr and the stream); slave: SRAM + consumer side.
interface sram_rd_streamer_if
   import npu_sram_pkg::*;
#(
   parameter int AW = SRAM_AW,
   parameter int DW = SRAM_DW
);

   logic          sram_enb;
   logic [AW-1:0] sram_addrb;
   logic [DW-1:0] sram_doutb;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;

   modport master (
      output sram_enb, sram_addrb,
      input  sram_doutb,
      output m_valid, m_data, m_last,
      input  m_ready
   );

   modport slave (
      input  sram_enb, sram_addrb,
      output sram_doutb,
      input  m_valid, m_data, m_last,
      output m_ready
   );

endinterface

// File: rtl/sync_fifo_skid.sv
// DEPTH x WIDTH single-clock shift-register FIFO; the head entry is a register.
// Ports: clk, rstn, flush, push, din, pop, dout (head), count (occupancy).
module sync_fifo_skid #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 65,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [CW-1:0]    wr_idx;
   logic             do_pop;
   logic             do_push;

   // Entries at or above the count are kept at zero, so the head
   // reads as zero whenever the FIFO is empty.
   always_comb begin
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((int'(cnt_q) != DEPTH) || do_pop);
      wr_idx  = do_pop ? cnt_q - CW'(1) : cnt_q;
      cnt_d   = cnt_q;
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CW'(1);
      end
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (do_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i+1];
         end
         mem_d[DEPTH-1] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (do_push && (int'(wr_idx) == i)) begin
            mem_d[i] = din;
         end
      end
   end

   // Flush wins over a same-cycle push or pop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign dout  = mem_q[0];
   assign count = cnt_q;

endmodule

// File: rtl/sram_rd_streamer.sv
// Read DMA: issues len SRAM reads from base, streams the words out with m_last.
// Ports: clk, rstn, start/base_addr/len/abort command, busy/done status, bus (SRAM + stream).
module sram_rd_streamer
   import npu_sram_pkg::*;
#(
   parameter int AW = SRAM_AW,
   parameter int DW = SRAM_DW,
   parameter int LW = SRAM_LW,
   parameter int FD = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [LW-1:0] len,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   sram_rd_streamer_if.master bus
);

   localparam int CW = $clog2(FD + 1);

   rd_state_e     state_q;
   logic [AW-1:0] addr_q;
   logic [LW-1:0] rem_q;
   logic          infl_q;
   logic          infl_last_q;
   logic          busy_q;
   logic          done_q;

   logic          issue;
   logic          pop;
   logic          flush;
   logic          hs_last;
   logic          m_valid;
   logic [CW-1:0] fcnt;
   logic [DW:0]   fdout;

   // A read may be issued while buffered + in-flight words leave a
   // free slot, or when the head leaves this cycle (keeps 1 word/cycle).
   always_comb begin
      m_valid = (fcnt != '0);
      pop     = m_valid && bus.m_ready;
      flush   = abort && (state_q != IDLE);
      hs_last = pop && fdout[DW];
      issue   = (state_q == ISSUE) && !abort && (rem_q != '0) &&
                (((int'(fcnt) + int'(infl_q)) < FD) || pop);
   end

   sync_fifo_skid #(
      .DEPTH (FD),
      .WIDTH (DW + 1)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .push  (infl_q),
      .din   ({infl_last_q, bus.sram_doutb}),
      .pop   (pop),
      .dout  (fdout),
      .count (fcnt)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         infl_q      <= issue;
         infl_last_q <= issue && (rem_q == LW'(1));
         if (issue) begin
            addr_q <= addr_q + AW'(1);
            rem_q  <= rem_q - LW'(1);
         end
         // issue is already gated by abort, so the in-flight word dies here.
         if (flush) begin
            state_q <= IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (start) begin
                     if (len != '0) begin
                        addr_q  <= base_addr;
                        rem_q   <= len;
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                     end else begin
                        done_q <= 1'b1;
                     end
                  end
               end
               ISSUE: begin
                  if (issue && (rem_q == LW'(1))) begin
                     state_q <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (hs_last) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.sram_enb   = issue;
   assign bus.sram_addrb = addr_q;
   assign bus.m_valid    = m_valid;
   assign bus.m_data     = fdout[DW-1:0];
   assign bus.m_last     = fdout[DW];
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Self-checking bench for sram_rd_streamer: SRAM model, directed and random commands.
// Expected beats come from a queue built from the memory image and (base, len).
module tb_sram_rd_streamer;
   import npu_sram_pkg::*;

   localparam int DEPTH = 1 << SRAM_AW;
   localparam int FD    = 2;

   logic                clk = 1'b0;
   logic                rstn;
   logic                start;
   logic                abort;
   logic                busy;
   logic                done;
   logic [SRAM_AW-1:0]  base_r;
   logic [SRAM_LW-1:0]  len_r;
   logic [SRAM_DW-1:0]  mem [DEPTH];
   int                  n_cmp = 0;
   int                  n_bad = 0;

   sram_rd_streamer_if bus ();

   sram_rd_streamer #(.FD(FD)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .base_addr (base_r),
      .len       (len_r),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // 1-cycle registered SRAM read port
   always @(posedge clk) begin
      if (bus.sram_enb) bus.sram_doutb <= mem[bus.sram_addrb];
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_enb"}, bus.sram_enb, 0);
      chk({tag, "_addr"}, bus.sram_addrb, 0);
      chk({tag, "_valid"}, bus.m_valid, 0);
      chk({tag, "_last"}, bus.m_last, 0);
      chk({tag, "_data"}, bus.m_data, 0);
   endtask

   task automatic idle_check(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         @(posedge clk); #1;
         start = 1'b0; abort = 1'b0; bus.m_ready = 1'b1;
         #1;
         chk("idle_done", done, 0);
         chk("idle_busy", busy, 0);
         chk("idle_enb", bus.sram_enb, 0);
         chk("idle_valid", bus.m_valid, 0);
      end
   endtask

   // Cycle 0 drives start; the DUT samples it at the edge closing cycle 0.
   // Unstalled: reads in cycles 1..n, beats in cycles 3..n+2, done in n+3.
   // rmode: 0 always ready, 1 toggling, 2 random. abort_at/rst_at: beat index or -1.
   task automatic run_cmd(input logic [SRAM_AW-1:0] base, input int n,
                          input int rmode, input int abort_at,
                          input int rst_at, input bit spur);
      logic [SRAM_DW-1:0] expd [$];
      logic [SRAM_DW-1:0] pd;
      logic pl, stall_prev, fin, hs, v_done;
      int c, beats, issued, dones, first_v, done_c, ab_c, budget, exp_beats;
      expd = {};
      for (int i = 0; i < n; i++) expd.push_back(mem[(int'(base) + i) % DEPTH]);
      c = 0; beats = 0; issued = 0; dones = 0; first_v = -1; done_c = -1;
      ab_c = -1; stall_prev = 0; fin = 0; pd = '0; pl = 0; v_done = 0;
      budget = 4 * n + 20;
      start = 1'b1; base_r = base; len_r = SRAM_LW'(n);
      while (!fin && c < budget) begin
         @(posedge clk); #1;
         c++;
         start = 1'b0;
         abort = 1'b0;
         if (spur && c == 3) begin
            start = 1'b1; base_r = 14'h1234; len_r = 15'd5;
         end
         case (rmode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = (c % 2) == 1;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
         if (ab_c < 0 && abort_at >= 0 && beats == abort_at && bus.m_valid) begin
            abort = 1'b1; bus.m_ready = 1'b0; ab_c = c;
         end
         if (rst_at >= 0 && beats == rst_at) begin
            rstn = 1'b0;
            #1;
            chk_zero("rst_async");
            @(posedge clk); #1;
            chk_zero("rst_held");
            rstn = 1'b1;
            #1;
            idle_check(4);
            return;
         end
         #1;
         if (bus.sram_enb) begin
            chk("rd_addr", bus.sram_addrb, (int'(base) + issued) % DEPTH);
            issued++;
         end
         if (rmode == 0 && abort_at < 0 && c <= n)
            chk("enb_back_to_back", bus.sram_enb, 1);
         hs = bus.m_valid && bus.m_ready;
         if (stall_prev && ab_c < 0) begin
            chk("stall_valid", bus.m_valid, 1);
            chk("stall_data", bus.m_data, pd);
            chk("stall_last", bus.m_last, pl);
         end
         if (first_v < 0 && bus.m_valid) first_v = c;
         if (hs) begin
            if (beats < n) begin
               chk("beat_data", bus.m_data, expd[beats]);
               chk("beat_last", bus.m_last, beats == n - 1);
            end else begin
               chk("extra_beat", beats, n - 1);
            end
            beats++;
         end
         if (bus.sram_enb) chk("fifo_plus_inflight", (issued - beats) <= FD, 1);
         stall_prev = bus.m_valid && !bus.m_ready;
         pd = bus.m_data;
         pl = bus.m_last;
         if (done) begin
            dones++; done_c = c; fin = 1; v_done = bus.m_valid;
            chk("busy_at_done", busy, 0);
         end else begin
            chk("busy_during_cmd", busy, n > 0);
         end
      end
      chk("cmd_timeout", fin, 1);
      exp_beats = (abort_at >= 0) ? abort_at : n;
      chk("beat_count", beats, exp_beats);
      chk("done_count", dones, 1);
      if (abort_at >= 0) begin
         chk("abort_done_cycle", done_c, ab_c + 1);
         chk("abort_valid", v_done, 0);
      end else begin
         chk("read_count", issued, n);
      end
      if (rmode == 0 && abort_at < 0) begin
         chk("first_beat_cycle", first_v, (n > 0) ? 3 : -1);
         chk("done_cycle", done_c, (n > 0) ? n + 3 : 1);
      end
      idle_check(3);
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; abort = 1'b0;
      base_r = '0; len_r = '0; bus.m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
      #12;
      chk_zero("reset");
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #2;
      bus.m_ready = 1'b1;

      run_cmd(14'h0010, 4, 0, -1, -1, 0);
      run_cmd(14'h3FFE, 4, 0, -1, -1, 0);
      run_cmd(14'($urandom), 8, 1, -1, -1, 1);
      run_cmd(14'($urandom), 8, 2, -1, -1, 0);
      for (int k = 0; k < 3; k++)
         run_cmd(14'($urandom), $urandom_range(1, 40), 2, -1, -1, 0);
      run_cmd(14'($urandom), 0, 0, -1, -1, 0);
      run_cmd(14'($urandom), 1, 0, -1, -1, 0);
      run_cmd(14'($urandom), 100, 0, 4, -1, 0);
      run_cmd(14'h0200, 2, 0, -1, -1, 0);
      run_cmd(14'($urandom), 50, 0, -1, 10, 0);
      run_cmd(14'($urandom), 20, 0, -1, -1, 0);
      run_cmd(14'($urandom), DEPTH, 0, -1, -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
